// File: rtl/uop_queue_pkg.sv
// Shared frontend definitions: the decoded micro-op entry carried from decode to rename.
package uop_queue_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int BHR_W = 10;

  typedef struct packed {
    logic             uop;
    logic             eoi;
    logic [REG_W-1:0] dr;
    logic [REG_W-1:0] sr1;
    logic [REG_W-1:0] sr2;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic [XLEN-1:0]  pc;
    logic             exception;
    logic [BHR_W-1:0] bhr;
  } uop_entry_t;

  localparam int ENTRY_W = $bits(uop_entry_t);

endpackage

// File: rtl/uop_queue_ram.sv
// Entry storage for the uop queue: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the pointer logic.
module uop_queue_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 93,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uop_queue.sv
// Decode-to-rename decoupling FIFO with a registered early stall that leaves SKID entries
// free for uops already in flight in the frontend when stall_out asserts.
module uop_queue #(
  parameter int XLEN  = uop_queue_pkg::XLEN,
  parameter int DEPTH = 8,
  parameter int SKID  = 2,
  parameter int BHR_W = uop_queue_pkg::BHR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic                     enq_uop,
  input  logic                     enq_eoi,
  input  logic [4:0]               enq_dr,
  input  logic [4:0]               enq_sr1,
  input  logic [4:0]               enq_sr2,
  input  logic [XLEN-1:0]          enq_imm,
  input  logic                     enq_use_imm,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic                     enq_exception,
  input  logic [BHR_W-1:0]         enq_bhr,
  output logic                     stall_out,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic                     deq_uop,
  output logic                     deq_eoi,
  output logic [4:0]               deq_dr,
  output logic [4:0]               deq_sr1,
  output logic [4:0]               deq_sr2,
  output logic [XLEN-1:0]          deq_imm,
  output logic                     deq_use_imm,
  output logic [XLEN-1:0]          deq_pc,
  output logic                     deq_exception,
  output logic [BHR_W-1:0]         deq_bhr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  import uop_queue_pkg::uop_entry_t;
  import uop_queue_pkg::ENTRY_W;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SKID - 1);

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count_next;
  logic          enq_fire, deq_fire, full;
  logic          stall_next, ovf_event;
  uop_entry_t    wr_entry, rd_entry;

  assign full      = (count == FULL_CNT);
  assign deq_valid = (count != '0);
  assign deq_fire  = deq_valid && deq_ready;
  assign enq_fire  = enq_valid && (!full || deq_fire) && !flush;
  // A flush-cycle enqueue is discarded by design, not a frontend protocol violation.
  assign ovf_event = enq_valid && full && !deq_fire && !flush;

  always_comb begin
    count_next = count;
    stall_next = 1'b0;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(enq_fire) - CW'(deq_fire);
      stall_next = (count_next > STALL_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      stall_out    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      count     <= count_next;
      stall_out <= stall_next;
      if (ovf_event) begin
        overflow_err <= 1'b1;
      end
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        // Power-of-two depth: pointer overflow is the wrap to entry 0.
        if (enq_fire) tail <= tail + 1'b1;
        if (deq_fire) head <= head + 1'b1;
      end
    end
  end

  always_comb begin
    wr_entry           = '0;
    wr_entry.uop       = enq_uop;
    wr_entry.eoi       = enq_eoi;
    wr_entry.dr        = enq_dr;
    wr_entry.sr1       = enq_sr1;
    wr_entry.sr2       = enq_sr2;
    wr_entry.imm       = enq_imm;
    wr_entry.use_imm   = enq_use_imm;
    wr_entry.pc        = enq_pc;
    wr_entry.exception = enq_exception;
    wr_entry.bhr       = enq_bhr;
  end

  uop_queue_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (enq_fire),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  assign deq_uop       = rd_entry.uop;
  assign deq_eoi       = rd_entry.eoi;
  assign deq_dr        = rd_entry.dr;
  assign deq_sr1       = rd_entry.sr1;
  assign deq_sr2       = rd_entry.sr2;
  assign deq_imm       = rd_entry.imm;
  assign deq_use_imm   = rd_entry.use_imm;
  assign deq_pc        = rd_entry.pc;
  assign deq_exception = rd_entry.exception;
  assign deq_bhr       = rd_entry.bhr;

endmodule

// File: doc/uop_queue.md
Name: uop_queue

Overview:
- Decoupling FIFO between the frontend decode output (uop, eoi, dr/sr1/sr2, imm, use_imm, pc, exception, bp_bhr) and the backend rename/dispatch stage.
- Absorbs backend back-pressure and returns a registered early stall (stall_out) to the frontend, which drives the frontend stall_in.
- The frontend pipeline keeps delivering uops for up to SKID cycles after stall_out asserts; the queue reserves room for them.
- Flushes all contents on resteer.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 8, number of entries; power of two, >= 4.
- SKID, 2, entries reserved for in-flight frontend uops after stall_out asserts; must be < DEPTH.
- BHR_W, 10, branch history width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  resteer/exception flush; discards all entries.
- enq_valid  in  1  frontend uop valid.
- enq_uop  in  1  micro-op encoding.
- enq_eoi  in  1  end-of-instruction flag.
- enq_dr, enq_sr1, enq_sr2  in  5 each  register specifiers.
- enq_imm  in  XLEN  immediate.
- enq_use_imm  in  1  immediate select.
- enq_pc  in  XLEN  uop PC.
- enq_exception  in  1  exception flag; the uop is treated as a NOP downstream.
- enq_bhr  in  BHR_W  branch history snapshot.
- stall_out  out  1  registered; to frontend stall_in.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  backend accepts head.
- deq_uop, deq_eoi, deq_dr, deq_sr1, deq_sr2, deq_imm, deq_use_imm, deq_pc, deq_exception, deq_bhr  out  (widths as enq_*)  head entry payload.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow_err  out  1  sticky; an enqueue was attempted while full.

Behaviour:
- Storage and pointers:
  - Circular buffer, DEPTH entries.
  - head and tail pointers are $clog2(DEPTH) bits; both wrap modulo DEPTH.
  - count is a separate register, range 0..DEPTH.
- Reset (rst low, asynchronous):
  - head = tail = count = 0.
  - stall_out = 0, overflow_err = 0, deq_valid = 0.
  - Payload storage is not reset.
- Enqueue:
  - Fires when enq_valid && (count < DEPTH || deq_fire) && !flush.
  - Writes the entry at tail; tail increments.
- Dequeue:
  - deq_fire = deq_valid && deq_ready.
  - head increments.
- Output timing:
  - deq_valid = (count != 0).
  - deq_* come combinationally from entry[head].
  - No bypass: a uop enqueued in cycle N is first visible on deq_* in cycle N+1.
- Simultaneous enqueue and dequeue:
  - count is unchanged and both pointers advance.
  - Allowed when full, provided deq_fire is true.
- Full:
  - enq_valid with count == DEPTH and !deq_fire drops the uop.
  - overflow_err sets and stays set until reset. This is a protocol violation and indicates a frontend SKID mismatch.
- Empty:
  - deq_valid = 0; deq_ready is ignored.
  - deq_* hold don't-care values.
- Flush:
  - Synchronous, takes priority over enqueue and dequeue in the same cycle.
  - Next cycle: head = tail = count = 0, deq_valid = 0.
  - An enq_valid uop in the flush cycle is discarded.
  - overflow_err is unaffected by flush.
- stall_out:
  - Registered.
  - Next value = (count_next > DEPTH - SKID - 1), i.e. asserted once free entries fall to SKID or fewer.
  - Forced to 0 on the cycle after a flush.
- count_next = count + enq_fire - deq_fire; set to 0 on flush.
- Pointer wrap: at DEPTH-1 the pointer advances to 0 with no bubble.

Decomposition:
- Shared frontend package:
  - uop_entry_t packed struct: uop, eoi, dr, sr1, sr2, imm, use_imm, pc, exception, bhr.
  - REG_W = 5 and BHR_W = 10 constants.
- One sub-module: uop_queue_ram, a DEPTH x $bits(uop_entry_t) register array with one write port and one asynchronous read port.
- Pointer, count and stall logic stay in uop_queue.

Test Plan:
- Reset with DEPTH=8, SKID=2, then enqueue pc=0x1000 in cycle 0 with deq_ready=1 → cycle 1: deq_valid=1, deq_pc=0x1000; cycle 2: deq_valid=0, count=0.
- Enqueue 6 uops with deq_ready=0 → stall_out=1 the cycle after count reaches 6. Push 2 more (skid) → count=8, overflow_err=0. Push a 9th → overflow_err=1, count stays 8.
- Full queue with deq_ready=1 and enq_valid=1 for 20 cycles → count stays 8, deq_pc sequence matches enqueue order across pointer wrap, no loss.
- Queue holding 5 entries, assert flush together with enq_valid and deq_ready → next cycle count=0, deq_valid=0, stall_out=0. Enqueue pc=0x2000 → it appears at head one cycle later.
- Enqueue a uop with exception=1, eoi=1, bhr=0x3FF → deq_exception=1, deq_eoi=1, deq_bhr=0x3FF; all payload fields bit-exact.
- Drive rst low mid-stream with count=4 and stall_out=1 → immediately count=0, deq_valid=0, stall_out=0 without waiting for a clock edge.
